// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared sizes, parameter word map and frame state type for the synth parameter path
//
// Contents:
//   PARAM_NWORDS / PARAM_WIDTH / PARAM_AW / PARAM_TIMEOUT : default frame geometry
//   FREQ_V0_BASE .. TRIG                                   : word index of each parameter group
//   pb_state_t                                             : frame controller state (IDLE, RX, COMMIT)
//   env_index()                                            : word index of an envelope field
package synth_pkg;

    localparam int PARAM_NWORDS  = 75;
    localparam int PARAM_WIDTH   = 32;
    localparam int PARAM_AW      = 7;
    localparam int PARAM_TIMEOUT = 4096;

    // Word map of one frame: voice frequencies, six envelopes of nine words, then mix/mod/trigger.
    localparam int FREQ_V0_BASE = 0;
    localparam int ENV_BASE     = 18;
    localparam int ENV_STRIDE   = 9;
    localparam int OMIX         = 72;
    localparam int IMOD         = 73;
    localparam int TRIG         = 74;

    // Encodings kept as plain constants so older code comparing raw state bits still lines up.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RX     = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        RX     = ST_RX,
        COMMIT = ST_COMMIT
    } pb_state_t;

    function automatic int env_index(input int env, input int field);
        return ENV_BASE + env * ENV_STRIDE + field;
    endfunction

endpackage

// File: rtl/param_frame_ctl.sv
// rtl/param_frame_ctl.sv - frame sequencing for the parameter bank: word index, timeout and link-drop abort
//
// Ports:
//   clk24       in   synth clock
//   rst_n       in   asynchronous active-low reset
//   word_valid  in   source has a word
//   link_busy   in   SPI transfer in progress
//   word_ready  out  a word can be taken this cycle (registered)
//   shadow_we   out  write word_data into the shadow bank this cycle
//   shadow_addr out  shadow index for that write
//   commit      out  copy shadow into active on this edge
//   abort       out  discard the partial frame on this edge
//   wr_index    out  next shadow index
module param_frame_ctl
    import synth_pkg::*;
#(
    parameter int NWORDS  = PARAM_NWORDS,
    parameter int AW      = PARAM_AW,
    parameter int TIMEOUT = PARAM_TIMEOUT
) (
    input  logic          clk24,
    input  logic          rst_n,
    input  logic          word_valid,
    input  logic          link_busy,
    output logic          word_ready,
    output logic          shadow_we,
    output logic [AW-1:0] shadow_addr,
    output logic          commit,
    output logic          abort,
    output logic [AW-1:0] wr_index
);

    localparam int TW = $clog2(TIMEOUT + 1);

    pb_state_t     state, state_nx;
    logic [AW-1:0] idx, idx_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          busy_q;
    logic          fall_pend, pend_nx;
    logic          ready_q;
    logic          accept;
    logic          busy_fall;
    logic          last_word;

    assign accept     = word_valid & ready_q;
    assign busy_fall  = busy_q & ~link_busy;
    assign last_word  = (idx == AW'(NWORDS - 1));

    assign word_ready  = ready_q;
    assign shadow_we   = accept;
    assign shadow_addr = idx;
    assign wr_index    = idx;

    // A link drop that coincides with a non-final word is remembered for one cycle
    // so the frame still aborts if the source then goes quiet.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        timer_nx = timer;
        pend_nx  = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = '0;
                if (accept) begin
                    if (NWORDS == 1) begin
                        idx_nx   = '0;
                        state_nx = COMMIT;
                    end else begin
                        idx_nx   = AW'(1);
                        pend_nx  = busy_fall;
                        state_nx = RX;
                    end
                end
            end
            RX: begin
                if (accept) begin
                    timer_nx = '0;
                    if (last_word) begin
                        idx_nx   = '0;
                        state_nx = COMMIT;
                    end else begin
                        idx_nx  = idx + AW'(1);
                        pend_nx = busy_fall;
                    end
                end else if (busy_fall || fall_pend || (timer == TW'(TIMEOUT - 1))) begin
                    abort    = 1'b1;
                    idx_nx   = '0;
                    timer_nx = '0;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                idx_nx   = '0;
                timer_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            timer     <= '0;
            busy_q    <= 1'b0;
            fall_pend <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            timer     <= timer_nx;
            busy_q    <= link_busy;
            fall_pend <= pend_nx;
            // Ready is registered so it stays low through reset and drops for the commit cycle only.
            ready_q   <= (state_nx != COMMIT);
        end
    end

endmodule

// File: rtl/param_bank.sv
// rtl/param_bank.sv - frame-coherent shadow/active parameter store fed by the SPI word stream
//
// Ports:
//   clk24       in   synth clock
//   rst_n       in   asynchronous active-low reset
//   word_data   in   WIDTH-bit word from the SPI receiver
//   word_valid  in   word present
//   word_ready  out  block can take a word
//   link_busy   in   SPI transfer in progress
//   params      out  active bank, word i at [i*WIDTH +: WIDTH]
//   rd_addr     in   readback address into the active bank
//   rd_data     out  active[rd_addr], one cycle later; 0 beyond the bank
//   frame_done  out  one-cycle pulse as the active bank updates
//   frame_err   out  one-cycle pulse when a partial frame is dropped
//   frame_cnt   out  committed frame count, wraps
//   wr_index    out  next shadow index
module param_bank
    import synth_pkg::*;
#(
    parameter int NWORDS  = PARAM_NWORDS,
    parameter int WIDTH   = PARAM_WIDTH,
    parameter int AW      = PARAM_AW,
    parameter int TIMEOUT = PARAM_TIMEOUT
) (
    input  logic                    clk24,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        word_data,
    input  logic                    word_valid,
    output logic                    word_ready,
    input  logic                    link_busy,
    output logic [NWORDS*WIDTH-1:0] params,
    input  logic [AW-1:0]           rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic [15:0]             frame_cnt,
    output logic [AW-1:0]           wr_index
);

    generate
        if (NWORDS > (2 ** AW)) begin : g_aw_too_small
            $error("param_bank: AW too narrow for NWORDS");
        end
    endgenerate

    logic [WIDTH-1:0] shadow [NWORDS];
    logic [WIDTH-1:0] active [NWORDS];
    logic             shadow_we;
    logic [AW-1:0]    shadow_addr;
    logic             commit;
    logic             abort;
    logic [WIDTH-1:0] rd_mux;

    param_frame_ctl #(
        .NWORDS  (NWORDS),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) u_ctl (
        .clk24       (clk24),
        .rst_n       (rst_n),
        .word_valid  (word_valid),
        .link_busy   (link_busy),
        .word_ready  (word_ready),
        .shadow_we   (shadow_we),
        .shadow_addr (shadow_addr),
        .commit      (commit),
        .abort       (abort),
        .wr_index    (wr_index)
    );

    // Shadow never sees a write during commit because ready is low then,
    // so the whole shadow bank is stable when it is copied.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                if (shadow_we && (shadow_addr == AW'(i))) begin
                    shadow[i] <= word_data;
                end
                if (commit) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NWORDS; g++) begin : g_params
            assign params[g*WIDTH +: WIDTH] = active[g];
        end
    endgenerate

    // Compare-select rather than direct indexing so addresses past the bank read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_mux = active[i];
            end
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            rd_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            rd_data    <= rd_mux;
            frame_done <= commit;
            frame_err  <= abort;
            if (commit) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_param_bank.sv
// tb/tb_param_bank.sv - self-checking bench for param_bank with a frame-level reference model
module tb_param_bank;
    import synth_pkg::*;

    localparam int NW = PARAM_NWORDS;
    localparam int W  = PARAM_WIDTH;
    localparam int AW = PARAM_AW;
    localparam int TO = PARAM_TIMEOUT;

    logic              clk24 = 1'b0;
    logic              rst_n = 1'b1;
    logic [W-1:0]      word_data = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic              link_busy = 1'b1;
    logic [NW*W-1:0]   params;
    logic [AW-1:0]     rd_addr = '0;
    logic [W-1:0]      rd_data;
    logic              frame_done;
    logic              frame_err;
    logic [15:0]       frame_cnt;
    logic [AW-1:0]     wr_index;

    param_bank dut (
        .clk24      (clk24),
        .rst_n      (rst_n),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .link_busy  (link_busy),
        .params     (params),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .wr_index   (wr_index)
    );

    always #20 clk24 = ~clk24;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame progress as a word count, a one-cycle gap after a full frame,
    // and a count of silent cycles since the last word.
    logic [W-1:0] m_shadow [NW];
    logic [W-1:0] m_active [NW];
    int           m_count;
    int           m_silence;
    bit           m_gap, m_pend, m_prev_busy, m_ready, m_done, m_err;
    logic [15:0]  m_cnt;
    logic [W-1:0] m_rd;

    task automatic m_reset();
        for (int i = 0; i < NW; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        m_count = 0; m_silence = 0;
        m_gap = 0; m_pend = 0; m_prev_busy = 0; m_ready = 0;
        m_done = 0; m_err = 0; m_cnt = '0; m_rd = '0;
    endtask

    task automatic m_step();
        bit acc, fall;
        acc  = word_valid && m_ready;
        fall = m_prev_busy && !link_busy;
        m_rd = (int'(rd_addr) < NW) ? m_active[rd_addr] : '0;
        m_done = 0;
        m_err  = 0;
        if (m_gap) begin
            for (int i = 0; i < NW; i++) m_active[i] = m_shadow[i];
            m_done = 1;
            m_cnt  = m_cnt + 16'd1;
            m_gap  = 0;
            m_pend = 0;
        end else if (acc) begin
            m_shadow[m_count] = word_data;
            m_silence = 0;
            if (m_count == NW - 1) begin
                m_gap = 1; m_count = 0; m_pend = 0;
            end else begin
                m_count++; m_pend = fall;
            end
        end else if (m_count > 0) begin
            if (fall || m_pend || (m_silence + 1 >= TO)) begin
                m_err = 1; m_count = 0; m_silence = 0;
            end else begin
                m_silence++;
            end
            m_pend = 0;
        end else begin
            m_pend = 0;
        end
        m_prev_busy = link_busy;
        m_ready = !m_gap;
    endtask

    initial begin : model_proc
        m_reset();
        forever begin
            @(posedge clk24 or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    bit cmp_en = 0;

    task automatic compare_all();
        logic [NW*W-1:0] e;
        for (int i = 0; i < NW; i++) e[i*W +: W] = m_active[i];
        chk("word_ready", 32'(word_ready), 32'(m_ready));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("wr_index", 32'(wr_index), 32'(m_count));
        chk("rd_data", rd_data, m_rd);
        checks++;
        if (params !== e) begin
            errors++;
            for (int i = 0; i < NW; i++) begin
                if (params[i*W +: W] !== e[i*W +: W]) begin
                    $display("FAIL params word %0d actual=0x%0h required=0x%0h at %0t",
                             i, params[i*W +: W], e[i*W +: W], $time);
                    break;
                end
            end
        end
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge clk24);
            if (cmp_en) compare_all();
        end
    end

    task automatic tick();
        @(negedge clk24);
        #1;
    endtask

    function automatic logic [W-1:0] pword(input int i);
        return params[i*W +: W];
    endfunction

    task automatic send_word(input logic [W-1:0] d, output int waited);
        int  n;
        bit  acc;
        n = 0;
        word_valid = 1'b1;
        word_data  = d;
        do begin
            acc = word_valid && m_ready;
            tick();
            n++;
        end while (!acc && n < 16);
        chk("send_word_accepted", 32'(acc), 32'd1);
        waited = n;
    endtask

    task automatic send_words(input logic [W-1:0] base, input int first, input int last);
        int w;
        for (int i = first; i <= last; i++) send_word(base + W'(i), w);
    endtask

    initial begin : stim
        int  w, n;
        bit  acc;

        #1 rst_n = 1'b0;
        #2 cmp_en = 1;
        repeat (3) tick();
        chk("reset_ready", 32'(word_ready), 32'd0);
        chk("reset_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_p26", pword(26), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(word_ready), 32'd1);

        // Full frame 0x1000+i
        send_words(32'h1000, 0, NW - 1);
        word_valid = 1'b0;
        chk("f1_ready_commit", 32'(word_ready), 32'd0);
        chk("f1_done_early", 32'(frame_done), 32'd0);
        tick();
        chk("f1_done", 32'(frame_done), 32'd1);
        chk("f1_ready_back", 32'(word_ready), 32'd1);
        chk("f1_p26", pword(26), 32'h101A);
        chk("f1_cnt", 32'(frame_cnt), 32'd1);
        tick();
        chk("f1_done_pulse", 32'(frame_done), 32'd0);

        // Link drop after 40 words
        send_words(32'h2000, 0, 39);
        word_valid = 1'b0;
        link_busy  = 1'b0;
        tick();
        chk("drop_err", 32'(frame_err), 32'd1);
        chk("drop_index", 32'(wr_index), 32'd0);
        chk("drop_p26", pword(26), 32'h101A);
        chk("drop_cnt", 32'(frame_cnt), 32'd1);
        link_busy = 1'b1;
        tick();
        chk("drop_err_pulse", 32'(frame_err), 32'd0);
        send_words(32'h2000, 0, NW - 1);
        word_valid = 1'b0;
        tick();
        chk("f2_done", 32'(frame_done), 32'd1);
        chk("f2_p26", pword(26), 32'h201A);
        chk("f2_cnt", 32'(frame_cnt), 32'd2);

        // Silence timeout after 10 words
        send_words(32'h6000, 0, 9);
        word_valid = 1'b0;
        n = 0;
        while (!frame_err && n < TO + 100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 32'd4096);
        chk("timeout_cnt", 32'(frame_cnt), 32'd2);
        chk("timeout_index", 32'(wr_index), 32'd0);

        // Word held across commit, plus readback of the trigger word
        rd_addr = 7'd74;
        send_words(32'h3000, 0, NW - 1);
        word_valid = 1'b1;
        word_data  = 32'hDEAD;
        chk("hold_ready_low", 32'(word_ready), 32'd0);
        tick();
        chk("hold_done", 32'(frame_done), 32'd1);
        chk("hold_index0", 32'(wr_index), 32'd0);
        chk("hold_rd_old", rd_data, 32'h204A);
        tick();
        chk("hold_index1", 32'(wr_index), 32'd1);
        chk("hold_rd_new", rd_data, 32'h304A);
        send_words(32'h4000, 1, NW - 2);
        send_word(32'h5, w);
        word_valid = 1'b0;
        chk("trig_rd_before", rd_data, 32'h304A);
        tick();
        chk("trig_done", 32'(frame_done), 32'd1);
        chk("trig_rd_commit_edge", rd_data, 32'h304A);
        tick();
        chk("trig_rd_after", rd_data, 32'h5);
        chk("trig_p0", pword(0), 32'hDEAD);
        chk("trig_p74", pword(TRIG), 32'h5);

        // Reset at word 60
        send_words(32'h7000, 0, 59);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_mid_index", 32'(wr_index), 32'd0);
        chk("rst_mid_ready", 32'(word_ready), 32'd0);
        chk("rst_mid_p74", pword(TRIG), 32'd0);
        chk("rst_mid_rd", rd_data, 32'd0);
        word_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_words(32'h5000, 0, NW - 1);
        word_valid = 1'b0;
        tick();
        chk("rst_next_done", 32'(frame_done), 32'd1);
        chk("rst_next_cnt", 32'(frame_cnt), 32'd1);
        chk("rst_next_p26", pword(26), 32'h501A);

        // Randomized traffic with occasional link drops and wide readback addresses
        acc = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!word_valid || acc) begin
                word_valid = ($urandom_range(0, 9) < 8);
                word_data  = $urandom;
            end
            link_busy = ($urandom_range(0, 149) != 0);
            rd_addr   = AW'($urandom_range(0, 127));
            acc = word_valid && m_ready;
            tick();
        end
        word_valid = 1'b0;
        link_busy  = 1'b1;
        repeat (4) tick();

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
